// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pixel-coordinate widths for the VGA game blocks
package vga_pkg;
  localparam int X_POS_W = 10;
  localparam int Y_POS_W = 10;
endpackage

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - pong ball position/direction FSM, stepped once per frame tick
module ball_motion
  import vga_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED_X     = 4,
  parameter int SPEED_Y     = 2,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               serve_i,
  input  logic               coll_left_i,
  input  logic               coll_right_i,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic               goal_left_o,
  output logic               goal_right_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [X_POS_W-1:0] CX     = X_POS_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_POS_W-1:0] CY     = Y_POS_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [X_POS_W-1:0] X_MAX  = X_POS_W'(SCREEN_W - BALL_SIZE);
  localparam logic [Y_POS_W-1:0] Y_MAX  = Y_POS_W'(SCREEN_H - BALL_SIZE);
  localparam logic [X_POS_W-1:0] STEP_X = X_POS_W'(SPEED_X);
  localparam logic [Y_POS_W-1:0] STEP_Y = Y_POS_W'(SPEED_Y);

  // Bound checks run one bit wider so x+size+step cannot wrap.
  localparam logic [X_POS_W:0] STEP_X_W = (X_POS_W + 1)'(SPEED_X);
  localparam logic [X_POS_W:0] SIZE_X_W = (X_POS_W + 1)'(BALL_SIZE);
  localparam logic [X_POS_W:0] SCR_X_W  = (X_POS_W + 1)'(SCREEN_W);
  localparam logic [Y_POS_W:0] STEP_Y_W = (Y_POS_W + 1)'(SPEED_Y);
  localparam logic [Y_POS_W:0] SIZE_Y_W = (Y_POS_W + 1)'(BALL_SIZE);
  localparam logic [Y_POS_W:0] SCR_Y_W  = (Y_POS_W + 1)'(SCREEN_H);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

  state_t             state_q, state_d;
  logic [X_POS_W-1:0] x_q, x_d;
  logic [Y_POS_W-1:0] y_q, y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic               hit_l_q, hit_l_d;
  logic               hit_r_q, hit_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               goal_left_d, goal_right_d;
  logic               hit_l_now, hit_r_now, dir_x_new;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      x_q          <= CX;
      y_q          <= CY;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      hit_l_q      <= 1'b0;
      hit_r_q      <= 1'b0;
      cnt_q        <= '0;
      goal_left_o  <= 1'b0;
      goal_right_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      hit_l_q      <= hit_l_d;
      hit_r_q      <= hit_r_d;
      cnt_q        <= cnt_d;
      goal_left_o  <= goal_left_d;
      goal_right_o <= goal_right_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    hit_l_d      = hit_l_q;
    hit_r_d      = hit_r_q;
    cnt_d        = cnt_q;
    goal_left_d  = 1'b0;
    goal_right_d = 1'b0;

    // A collision level on the tick cycle itself still counts for this frame.
    hit_l_now = hit_l_q | coll_left_i;
    hit_r_now = hit_r_q | coll_right_i;
    dir_x_new = dir_x_q;
    if (hit_l_now && !hit_r_now) begin
      dir_x_new = 1'b1;
    end else if (hit_r_now && !hit_l_now) begin
      dir_x_new = 1'b0;
    end

    case (state_q)
      IDLE: begin
        x_d     = CX;
        y_d     = CY;
        hit_l_d = 1'b0;
        hit_r_d = 1'b0;
        cnt_d   = '0;
        if (serve_i) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        hit_l_d = hit_l_now;
        hit_r_d = hit_r_now;
        if (frame_tick_i) begin
          hit_l_d = 1'b0;
          hit_r_d = 1'b0;
          dir_x_d = dir_x_new;
          if (!dir_x_new) begin
            if ({1'b0, x_q} <= STEP_X_W) begin
              x_d         = '0;
              goal_left_d = 1'b1;
              state_d     = SCORED;
              cnt_d       = '0;
            end else begin
              x_d = x_q - STEP_X;
            end
          end else begin
            if ({1'b0, x_q} + SIZE_X_W + STEP_X_W >= SCR_X_W) begin
              x_d          = X_MAX;
              goal_right_d = 1'b1;
              state_d      = SCORED;
              cnt_d        = '0;
            end else begin
              x_d = x_q + STEP_X;
            end
          end
          if (!dir_y_q) begin
            if ({1'b0, y_q} <= STEP_Y_W) begin
              y_d     = '0;
              dir_y_d = 1'b1;
            end else begin
              y_d = y_q - STEP_Y;
            end
          end else begin
            if ({1'b0, y_q} + SIZE_Y_W + STEP_Y_W >= SCR_Y_W) begin
              y_d     = Y_MAX;
              dir_y_d = 1'b0;
            end else begin
              y_d = y_q + STEP_Y;
            end
          end
        end
      end

      SCORED: begin
        // dir_x already points at the conceding side, so it is left as is.
        if (frame_tick_i) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = IDLE;
            x_d     = CX;
            y_d     = CY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ball_x_o = x_q;
  assign ball_y_o = y_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - scoreboard bench for ball_motion with default parameters
module tb_ball_motion;
  import vga_pkg::*;

  localparam int W = 640, H = 480, BS = 8, SX = 4, SY = 2, HOLD = 60;
  localparam int CXE = 316, CYE = 236;

  logic               clk_i = 1'b0;
  logic               rst_i, frame_tick_i, serve_i, coll_left_i, coll_right_i;
  logic [X_POS_W-1:0] ball_x_o;
  logic [Y_POS_W-1:0] ball_y_o;
  logic               goal_left_o, goal_right_o;
  logic [1:0]         state_o;

  ball_motion dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_tick_i(frame_tick_i), .serve_i(serve_i),
    .coll_left_i(coll_left_i), .coll_right_i(coll_right_i),
    .ball_x_o(ball_x_o), .ball_y_o(ball_y_o),
    .goal_left_o(goal_left_o), .goal_right_o(goal_right_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [X_POS_W-1:0] x;
    logic [Y_POS_W-1:0] y;
    logic [1:0]         st;
    logic               gl;
    logic               gr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   m_x, m_y, m_dx, m_dy, m_st, m_cnt, m_last;
  bit   m_hl, m_hr;

  task automatic model_reset();
    m_x = CXE; m_y = CYE; m_dx = 1; m_dy = 1; m_st = 0; m_cnt = 0; m_last = 1;
    m_hl = 0; m_hr = 0;
    exp_q.delete();
  endtask

  // Drives one clock of stimulus, predicts the registered result, returns at the next negedge.
  task automatic drive(input logic tk, input logic srv, input logic cl, input logic cr);
    exp_t e;
    bit   hl, hr;
    frame_tick_i = tk; serve_i = srv; coll_left_i = cl; coll_right_i = cr;
    e.gl = 0; e.gr = 0;
    if (m_st == 0) begin
      if (srv) begin m_st = 1; m_hl = 0; m_hr = 0; end
    end else if (m_st == 1) begin
      hl = m_hl | cl;
      hr = m_hr | cr;
      if (tk) begin
        if (hl && !hr) m_dx = 1;
        else if (hr && !hl) m_dx = 0;
        if (m_dx == 0) begin
          if (m_x <= SX) begin m_x = 0; e.gl = 1; m_st = 2; m_cnt = 0; m_last = 0; end
          else m_x = m_x - SX;
        end else begin
          if (m_x + BS + SX >= W) begin m_x = W - BS; e.gr = 1; m_st = 2; m_cnt = 0; m_last = 1; end
          else m_x = m_x + SX;
        end
        if (m_dy == 0) begin
          if (m_y <= SY) begin m_y = 0; m_dy = 1; end
          else m_y = m_y - SY;
        end else begin
          if (m_y + BS + SY >= H) begin m_y = H - BS; m_dy = 0; end
          else m_y = m_y + SY;
        end
        m_hl = 0; m_hr = 0;
      end else begin
        m_hl = hl; m_hr = hr;
      end
    end else if (tk) begin
      m_cnt++;
      if (m_cnt == HOLD) begin m_st = 0; m_x = CXE; m_y = CYE; m_dx = m_last; m_cnt = 0; end
    end
    e.x = X_POS_W'(m_x); e.y = Y_POS_W'(m_y); e.st = 2'(m_st);
    exp_q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    frame_tick_i = 0; serve_i = 0; coll_left_i = 0; coll_right_i = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_i = 1; frame_tick_i = 0; serve_i = 0; coll_left_i = 0; coll_right_i = 0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !==
        {X_POS_W'(CXE), Y_POS_W'(CYE), 2'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_values: got x=%0d y=%0d st=%0d gl=%b gr=%b want x=316 y=236 st=0 gl=0 gr=0",
               ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o);
    end
    rst_i = 0;
    model_reset();
    drive(1, 0, 1, 1);
    e = exp_q.pop_front(); n_cmp++;
    if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !== {e.x, e.y, e.st, e.gl, e.gr}) begin
      n_bad++;
      $display("FAIL idle_hold: got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d", ball_x_o, ball_y_o, state_o, e.x, e.y, e.st);
    end
  endtask

  task automatic test_serve_run();
    exp_t e;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(1, 0, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !== {e.x, e.y, e.st, e.gl, e.gr}) begin
        n_bad++;
        $display("FAIL serve_run: got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d", ball_x_o, ball_y_o, state_o, e.x, e.y, e.st);
      end
    end
    n_cmp++;
    if (ball_x_o !== X_POS_W'(328) || ball_y_o !== Y_POS_W'(242) || state_o !== 2'd1) begin
      n_bad++;
      $display("FAIL serve_3ticks: got x=%0d y=%0d st=%0d want x=328 y=242 st=1", ball_x_o, ball_y_o, state_o);
    end
  endtask

  task automatic test_paddle_flip();
    exp_t       e;
    logic [3:0] stim[$];
    stim = '{4'b0001, 4'b0000, 4'b1000,
             4'b0001, 4'b1001, 4'b0001, 4'b1001, 4'b0001, 4'b1001,
             4'b0001, 4'b1001, 4'b0001, 4'b1001, 4'b1010};
    foreach (stim[i]) begin
      drive(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      e = exp_q.pop_front(); n_cmp++;
      if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !== {e.x, e.y, e.st, e.gl, e.gr}) begin
        n_bad++;
        $display("FAIL paddle_flip[%0d]: got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d", i, ball_x_o, ball_y_o, state_o, e.x, e.y, e.st);
      end
      if (i == 2 || i == 12 || i == 13) begin
        n_cmp++;
        if (ball_x_o !== X_POS_W'((i == 2) ? 324 : (i == 12) ? 304 : 308)) begin
          n_bad++;
          $display("FAIL paddle_x[%0d]: got x=%0d want x=%0d", i, ball_x_o, (i == 2) ? 324 : (i == 12) ? 304 : 308);
        end
      end
    end
  endtask

  task automatic test_both_and_serve_ignore();
    exp_t       e;
    logic [3:0] stim[$];
    stim = '{4'b0010, 4'b0001, 4'b1000, 4'b1011, 4'b1100};
    foreach (stim[i]) begin
      drive(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      e = exp_q.pop_front(); n_cmp++;
      if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !== {e.x, e.y, e.st, e.gl, e.gr}) begin
        n_bad++;
        $display("FAIL both_flags[%0d]: got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d", i, ball_x_o, ball_y_o, state_o, e.x, e.y, e.st);
      end
    end
    n_cmp++;
    if (ball_x_o !== X_POS_W'(320) || state_o !== 2'd1) begin
      n_bad++;
      $display("FAIL both_dir_kept: got x=%0d st=%0d want x=320 st=1", ball_x_o, state_o);
    end
  endtask

  task automatic test_wall_y();
    exp_t e;
    bit   cl, cr, saw_top = 0, saw_bot = 0, after_top = 0, pend = 0;
    int   pre_y, pre_dy;
    for (int i = 0; i < 600 && !(saw_top && saw_bot && after_top); i++) begin
      pre_y = m_y; pre_dy = m_dy;
      cl = (m_dx == 0 && m_x <= 12);
      cr = (m_dx == 1 && m_x >= 616);
      drive(1, 0, cl, cr);
      e = exp_q.pop_front(); n_cmp++;
      if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !== {e.x, e.y, e.st, e.gl, e.gr}) begin
        n_bad++;
        $display("FAIL rally[%0d]: got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d", i, ball_x_o, ball_y_o, state_o, e.x, e.y, e.st);
      end
      if (pend) begin
        n_cmp++; pend = 0; after_top = 1;
        if (ball_y_o !== Y_POS_W'(2)) begin n_bad++; $display("FAIL top_rebound: got y=%0d want y=2", ball_y_o); end
      end
      if (pre_y == 2 && pre_dy == 0) begin
        n_cmp++; saw_top = 1; pend = 1;
        if (ball_y_o !== Y_POS_W'(0)) begin n_bad++; $display("FAIL top_clamp: got y=%0d want y=0", ball_y_o); end
      end
      if (pre_y == 470 && pre_dy == 1) begin
        n_cmp++; saw_bot = 1;
        if (ball_y_o !== Y_POS_W'(472)) begin n_bad++; $display("FAIL bottom_clamp: got y=%0d want y=472", ball_y_o); end
      end
    end
    n_cmp++;
    if (!(saw_top && saw_bot && after_top)) begin
      n_bad++;
      $display("FAIL wall_y_reach: got top=%0d bottom=%0d rebound=%0d want all 1", saw_top, saw_bot, after_top);
    end
  endtask

  task automatic test_goal(input bit left);
    exp_t e;
    drive(0, 0, !left, left);
    e = exp_q.pop_front();
    for (int i = 0; i < 200 && m_st == 1; i++) begin
      drive(1, 0, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !== {e.x, e.y, e.st, e.gl, e.gr}) begin
        n_bad++;
        $display("FAIL run_to_goal[%0d]: got x=%0d y=%0d st=%0d gl=%b gr=%b want x=%0d y=%0d st=%0d gl=%b gr=%b",
                 i, ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o, e.x, e.y, e.st, e.gl, e.gr);
      end
    end
    n_cmp++;
    if (ball_x_o !== X_POS_W'(left ? 0 : 632) || state_o !== 2'd2 || goal_left_o !== left || goal_right_o !== !left) begin
      n_bad++;
      $display("FAIL goal_hit: got x=%0d st=%0d gl=%b gr=%b want x=%0d st=2 gl=%b gr=%b",
               ball_x_o, state_o, goal_left_o, goal_right_o, left ? 0 : 632, left, !left);
    end
    // Serve and collisions during SCORED must be ignored; goal pulse must drop.
    for (int i = 0; i <= HOLD; i++) begin
      if (i == 0) drive(0, 1, 1, 1);
      else drive(1, i[0], i[1], i[2]);
      e = exp_q.pop_front(); n_cmp++;
      if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !== {e.x, e.y, e.st, e.gl, e.gr}) begin
        n_bad++;
        $display("FAIL hold[%0d]: got x=%0d y=%0d st=%0d gl=%b gr=%b want x=%0d y=%0d st=%0d gl=%b gr=%b",
                 i, ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o, e.x, e.y, e.st, e.gl, e.gr);
      end
    end
    n_cmp++;
    if (state_o !== 2'd0 || ball_x_o !== X_POS_W'(CXE) || ball_y_o !== Y_POS_W'(CYE)) begin
      n_bad++;
      $display("FAIL hold_return: got x=%0d y=%0d st=%0d want x=316 y=236 st=0", ball_x_o, ball_y_o, state_o);
    end
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      if (i == 1) begin
        n_cmp++;
        if ({ball_x_o, ball_y_o, state_o} !== {e.x, e.y, e.st} || ball_x_o !== X_POS_W'(left ? 312 : 320)) begin
          n_bad++;
          $display("FAIL reserve_dir: got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d", ball_x_o, ball_y_o, state_o, e.x, e.y, e.st);
        end
      end
    end
  endtask

  task automatic test_serve_tick();
    exp_t e;
    rst_i = 1; @(negedge clk_i); rst_i = 0;
    model_reset();
    drive(1, 1, 0, 0);
    e = exp_q.pop_front(); n_cmp++;
    if ({ball_x_o, ball_y_o, state_o} !== {e.x, e.y, e.st} || ball_x_o !== X_POS_W'(CXE) || state_o !== 2'd1) begin
      n_bad++;
      $display("FAIL serve_on_tick: got x=%0d y=%0d st=%0d want x=316 y=236 st=1", ball_x_o, ball_y_o, state_o);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 200 && m_st == 1; i++) begin
      drive(1, 0, 0, 0);
      e = exp_q.pop_front(); n_cmp++;
      if ({ball_x_o, ball_y_o, state_o, goal_right_o} !== {e.x, e.y, e.st, e.gr}) begin
        n_bad++;
        $display("FAIL pre_reset_run[%0d]: got x=%0d st=%0d want x=%0d st=%0d", i, ball_x_o, state_o, e.x, e.st);
      end
    end
    #2 rst_i = 1;
    #1;
    n_cmp++;
    if ({ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o} !==
        {X_POS_W'(CXE), Y_POS_W'(CYE), 2'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL async_reset_scored: got x=%0d y=%0d st=%0d gl=%b gr=%b want x=316 y=236 st=0 gl=0 gr=0",
               ball_x_o, ball_y_o, state_o, goal_left_o, goal_right_o);
    end
    @(negedge clk_i); rst_i = 0;
    model_reset();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
    end
    n_cmp++;
    if (ball_x_o !== X_POS_W'(320) || state_o !== 2'd1) begin
      n_bad++;
      $display("FAIL pre_reset_play: got x=%0d st=%0d want x=320 st=1", ball_x_o, state_o);
    end
    #2 rst_i = 1;
    #1;
    n_cmp++;
    if ({ball_x_o, ball_y_o, state_o} !== {X_POS_W'(CXE), Y_POS_W'(CYE), 2'd0}) begin
      n_bad++;
      $display("FAIL async_reset_play: got x=%0d y=%0d st=%0d want x=316 y=236 st=0", ball_x_o, ball_y_o, state_o);
    end
    @(negedge clk_i); rst_i = 0;
    model_reset();
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    e = exp_q.pop_front();
    e = exp_q.pop_front(); n_cmp++;
    if ({ball_x_o, ball_y_o, state_o} !== {e.x, e.y, e.st} || ball_x_o !== X_POS_W'(320) || ball_y_o !== Y_POS_W'(238)) begin
      n_bad++;
      $display("FAIL flags_discarded: got x=%0d y=%0d st=%0d want x=320 y=238 st=1", ball_x_o, ball_y_o, state_o);
    end
  endtask

  initial begin
    test_reset();
    test_serve_run();
    test_paddle_flip();
    test_both_and_serve_ignore();
    test_wall_y();
    test_goal(1'b1);
    test_goal(1'b0);
    test_serve_tick();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000 want finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
